// File: rtl/ime_fisher_accum.sv
// ime_fisher_accum: sums Fisher-term beats into one saturated per-packet score with count and flags
module ime_fisher_accum #(
  parameter int W_ACC = 32,
  parameter int K_MAX = 4096,
  localparam int CW = $clog2(K_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_ACC-1:0] in_term,
  input  logic             in_last,
  input  logic             in_poison,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_ACC-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_poison,
  output logic             out_overflow
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state;
  logic [W_ACC-1:0] acc, sum_next;
  logic [W_ACC:0]   sum_wide;
  logic [CW-1:0]    count, cnt_next;
  logic             psn_s, ovf_s, psn_next, ovf_next, force_close, close, take;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == HOLD;
  // next-value datapath for the beat being accepted; a carry pins the sum at all-ones
  always_comb begin
    take        = in_valid && in_ready;
    sum_wide    = {1'b0, acc} + {1'b0, in_term};
    sum_next    = sum_wide[W_ACC] ? '1 : sum_wide[W_ACC-1:0];
    ovf_next    = ovf_s | sum_wide[W_ACC];
    cnt_next    = count + CW'(1);
    force_close = cnt_next == CW'(K_MAX) && !in_last;
    close       = in_last || cnt_next == CW'(K_MAX);
    psn_next    = psn_s | in_poison | force_close;
  end
  // accumulate beats, latch the result on close, hold it until the downstream handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      psn_s        <= 1'b0;
      ovf_s        <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_poison   <= 1'b0;
      out_overflow <= 1'b0;
    end else if (take && close) begin
      state        <= HOLD;
      out_sum      <= sum_next;
      out_count    <= cnt_next;
      out_poison   <= psn_next;
      out_overflow <= ovf_next;
      acc          <= '0;
      count        <= '0;
      psn_s        <= 1'b0;
      ovf_s        <= 1'b0;
    end else if (take) begin
      acc          <= sum_next;
      count        <= cnt_next;
      psn_s        <= psn_next;
      ovf_s        <= ovf_next;
    end else if (out_valid && out_ready) begin
      state        <= ACCUM;
      out_sum      <= '0;
      out_count    <= '0;
      out_poison   <= 1'b0;
      out_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ime_fisher_accum.sv
// tb_ime_fisher_accum: vector table, corner sequences and random packets against a saturating-sum model
module tb_ime_fisher_accum;
  localparam int K = 4;
  localparam int CW = 3;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, in_poison = 0, out_ready = 1;
  logic [31:0] in_term = '0;
  logic in_ready, out_valid, out_poison, out_overflow;
  logic [31:0] out_sum;
  logic [CW-1:0] out_count;
  int checks = 0, errors = 0;

  typedef struct {
    int n;
    logic [3:0][31:0] t;
    logic [3:0] p;
    bit last;
    logic [31:0] es;
    int ec;
    bit ep;
    bit eo;
  } vec_t;

  vec_t vt[8];

  ime_fisher_accum #(.W_ACC(32), .K_MAX(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_term(in_term),
    .in_last(in_last), .in_poison(in_poison),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_poison(out_poison), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    longint unsigned s = 0;
    bit pz = 0;
    for (int i = 0; i < v.n; i++) begin
      s += v.t[i];
      pz |= v.p[i];
    end
    v.es = s > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : s[31:0];
    v.eo = s > 64'hFFFF_FFFF;
    v.ec = v.n;
    v.ep = pz | (v.n == K && !v.last);
    return v;
  endfunction

  task automatic send(input logic [31:0] t, input bit l, input bit p);
    bit ok = 0;
    in_valid = 1; in_term = t; in_last = l; in_poison = p;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("send ready", ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic get_res(input string nm, input vec_t v);
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk({nm, " valid"}, ok, 1);
    chk({nm, " sum"}, out_sum, v.es);
    chk({nm, " count"}, out_count, v.ec);
    chk({nm, " poison"}, out_poison, v.ep);
    chk({nm, " overflow"}, out_overflow, v.eo);
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit gaps);
    for (int i = 0; i < v.n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send(v.t[i], v.last && i == v.n - 1, v.p[i]);
    end
    get_res(nm, v);
  endtask

  initial begin
    vec_t r;
    vt[0] = '{n:3, t:{32'd0, 32'd30, 32'd20, 32'd10}, p:4'b0000, last:1, es:32'd60, ec:3, ep:0, eo:0};
    vt[1] = '{n:3, t:{32'd0, 32'd9, 32'd7, 32'd5}, p:4'b0010, last:1, es:32'd21, ec:3, ep:1, eo:0};
    vt[2] = '{n:1, t:{32'd0, 32'd0, 32'd0, 32'd4}, p:4'b0000, last:1, es:32'd4, ec:1, ep:0, eo:0};
    vt[3] = '{n:3, t:{32'd0, 32'd1, 32'h20, 32'hFFFF_FFF0}, p:4'b0000, last:1, es:32'hFFFF_FFFF, ec:3, ep:0, eo:1};
    vt[4] = '{n:4, t:{32'd1, 32'd1, 32'd1, 32'd1}, p:4'b0000, last:0, es:32'd4, ec:4, ep:1, eo:0};
    vt[5] = '{n:1, t:{32'd0, 32'd0, 32'd0, 32'd0}, p:4'b0001, last:1, es:32'd0, ec:1, ep:1, eo:0};
    vt[6] = '{n:4, t:{32'd5, 32'd4, 32'd3, 32'd2}, p:4'b0000, last:1, es:32'd14, ec:4, ep:0, eo:0};
    vt[7] = '{n:2, t:{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, p:4'b0000, last:1, es:32'hFFFF_FFFF, ec:2, ep:0, eo:0};

    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_count", out_count, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i], 0);

    // result appears one cycle after the closing beat, with a one-bubble turnaround
    send(10, 0, 0); send(20, 0, 0); send(30, 1, 0);
    chk("lat out_valid", out_valid, 1);
    chk("lat in_ready", in_ready, 0);
    chk("lat out_sum", out_sum, 60);
    @(posedge clk); #1;
    chk("turn in_ready", in_ready, 1);
    chk("turn out_valid", out_valid, 0);

    // force-close at K beats, then a stalled result with the next beat waiting
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(1, 0, 0);
    in_valid = 1; in_term = 7; in_last = 1; in_poison = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall in_ready", in_ready, 0);
      chk("stall out_valid", out_valid, 1);
      chk("stall out_sum", out_sum, 4);
      chk("stall out_count", out_count, 4);
      chk("stall out_poison", out_poison, 1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("hs out_valid", out_valid, 0);
    chk("hs in_ready", in_ready, 1);
    chk("hs out_sum cleared", out_sum, 0);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    chk("next out_valid", out_valid, 1);
    chk("next out_sum", out_sum, 7);
    chk("next out_count", out_count, 1);
    chk("next out_poison", out_poison, 0);
    @(posedge clk); #1;

    // reset mid-packet discards the partial sum
    send(1, 0, 0); send(2, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("rst mid out_valid", out_valid, 0);
    chk("rst mid out_sum", out_sum, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    r = '{n:1, t:{32'd0, 32'd0, 32'd0, 32'd3}, p:4'b0000, last:1, es:32'd3, ec:1, ep:0, eo:0};
    run_vec("after rst", r, 0);

    // reset while a result is being held clears it immediately
    @(posedge clk); #1;
    out_ready = 0;
    send(9, 1, 1);
    chk("hold pre out_sum", out_sum, 9);
    #2 rst_n = 0;
    #1;
    chk("rst hold out_valid", out_valid, 0);
    chk("rst hold out_sum", out_sum, 0);
    chk("rst hold out_poison", out_poison, 0);
    @(negedge clk); rst_n = 1; out_ready = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      r.n = $urandom_range(1, K);
      r.last = r.n < K ? 1'b1 : 1'($urandom_range(0, 1));
      r.t = '0;
      r.p = '0;
      for (int j = 0; j < r.n; j++) begin
        case ($urandom_range(0, 3))
          0: r.t[j] = $urandom_range(0, 100);
          1: r.t[j] = 32'hFFFF_0000 | $urandom;
          2: r.t[j] = $urandom;
          default: r.t[j] = 0;
        endcase
        r.p[j] = $urandom_range(0, 7) == 0;
      end
      r = model(r);
      run_vec($sformatf("rnd%0d", i), r, 1);
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
